// File: rtl/shift_counter_pkg.sv
// rtl/shift_counter_pkg.sv - shared types and helpers for the shift_counter block
package shift_counter_pkg;

  typedef enum logic {MODE_JOHNSON = 1'b0, MODE_RING = 1'b1} sc_mode_e;

  localparam int SC_MAX_W = 32;

  function automatic int sc_popcount(input logic [SC_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < SC_MAX_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Johnson-legal means the ones form one run touching the MSB or the LSB.
  function automatic logic sc_is_legal(input logic [SC_MAX_W-1:0] v, input int w,
                                       input sc_mode_e mode);
    logic [SC_MAX_W-1:0] mask;
    logic [SC_MAX_W-1:0] vm;
    logic [SC_MAX_W-1:0] nv;
    mask = {SC_MAX_W{1'b1}} >> (SC_MAX_W - w);
    vm   = v & mask;
    nv   = ~v & mask;
    if (mode == MODE_RING) return (sc_popcount(vm) == 1);
    return ((vm & (vm + SC_MAX_W'(1))) == '0) || ((nv & (nv + SC_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// rtl/shift_counter_decode.sv - combinational phase index and legality decode of q
module shift_counter_decode
  import shift_counter_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0]           q_i,
  input  logic                   mode_i,
  output logic [$clog2(2*W)-1:0] phase_o,
  output logic                   legal_o
);

  logic [SC_MAX_W-1:0] qx;
  int                  cnt;
  int                  ph;

  assign qx = SC_MAX_W'(q_i);

  always_comb begin
    cnt     = sc_popcount(qx);
    legal_o = sc_is_legal(qx, W, sc_mode_e'(mode_i));
    ph      = 0;
    if (mode_i) begin
      for (int i = 0; i < W; i++) begin
        if (q_i[i]) ph = W - 1 - i;
      end
    end else if (q_i[W-1] || (q_i == '0)) begin
      ph = cnt;
    end else begin
      ph = 2 * W - cnt;
    end
    if (!legal_o) ph = 0;
    phase_o = ($clog2(2*W))'(ph);
  end

endmodule

// File: rtl/shift_counter.sv
// rtl/shift_counter.sv - W-bit Johnson/ring shift counter with load, phase and wrap
// Optional illegal-state self-correction: SHIFT_COUNTER_SELFCORRECT_EN
module shift_counter
  import shift_counter_pkg::*;
#(
  parameter int W = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic                   up_i,
  input  logic                   mode_i,
  input  logic                   load_i,
  input  logic [W-1:0]           load_val_i,
  output logic [W-1:0]           q_o,
  output logic [$clog2(2*W)-1:0] phase_o,
  output logic                   wrap_o,
  output logic                   illegal_o
);

  localparam logic [W-1:0] RING_BASE = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] step_q;
  logic         mode_q;
  logic         wrap_q, wrap_d;
  logic         legal;

  function automatic logic [W-1:0] base_of(input logic m);
    return m ? RING_BASE : '0;
  endfunction

  shift_counter_decode #(.W(W)) u_decode (
    .q_i     (q_q),
    .mode_i  (mode_q),
    .phase_o (phase_o),
    .legal_o (legal)
  );

  always_comb begin
    if (mode_q) step_q = up_i ? {q_q[0], q_q[W-1:1]} : {q_q[W-2:0], q_q[W-1]};
    else        step_q = up_i ? {~q_q[0], q_q[W-1:1]} : {q_q[W-2:0], ~q_q[W-1]};
  end

  // Only a genuine return to the base state counts as a wrap.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (mode_i != mode_q) begin
      q_d = base_of(mode_i);
    end else if (load_i) begin
`ifdef SHIFT_COUNTER_SELFCORRECT_EN
      q_d = sc_is_legal(SC_MAX_W'(load_val_i), W, sc_mode_e'(mode_q)) ? load_val_i
                                                                      : base_of(mode_q);
`else
      q_d = load_val_i;
`endif
    end
`ifdef SHIFT_COUNTER_SELFCORRECT_EN
    else if (!legal) begin
      q_d = base_of(mode_q);
    end
`endif
    else if (en_i) begin
      q_d    = step_q;
      wrap_d = legal && (step_q == base_of(mode_q));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q    <= base_of(mode_i);
      mode_q <= mode_i;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_i;
      wrap_q <= wrap_d;
    end
  end

  assign q_o    = q_q;
  assign wrap_o = wrap_q;
`ifdef SHIFT_COUNTER_SELFCORRECT_EN
  assign illegal_o = ~legal;
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_shift_counter.sv
// tb/tb_shift_counter.sv - scoreboard bench for shift_counter (W=3 and W=8 instances)
module tb_shift_counter;

  logic       clk;
  logic       reset, en, up, mode, load;
  logic [7:0] load_val8;
  logic [2:0] load_val3;
  logic [2:0] q3;
  logic [2:0] ph3;
  logic       wrap3, ill3;
  logic [7:0] q8;
  logic [3:0] ph8;
  logic       wrap8, ill8;

  typedef struct {
    bit         big;
    logic [7:0] q;
    logic [3:0] ph;
    logic       wr;
    logic       il;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] aq;
  logic [3:0] aph;
  logic       awr, ail;

  assign load_val3 = load_val8[2:0];

  shift_counter #(.W(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .en_i(en), .up_i(up), .mode_i(mode), .load_i(load),
    .load_val_i(load_val3), .q_o(q3), .phase_o(ph3), .wrap_o(wrap3), .illegal_o(ill3)
  );

  shift_counter #(.W(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .en_i(en), .up_i(up), .mode_i(mode), .load_i(load),
    .load_val_i(load_val8), .q_o(q8), .phase_o(ph8), .wrap_o(wrap8), .illegal_o(ill8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        aq  = e.big ? q8 : {5'b0, q3};
        aph = e.big ? ph8 : {1'b0, ph3};
        awr = e.big ? wrap8 : wrap3;
        ail = e.big ? ill8 : ill3;
        checks++;
        if (aq !== e.q || aph !== e.ph || awr !== e.wr || ail !== e.il) begin
          errors++;
          $display("FAIL %s: got q=%h phase=%0d wrap=%b illegal=%b, want q=%h phase=%0d wrap=%b illegal=%b",
                   e.nm, aq, aph, awr, ail, e.q, e.ph, e.wr, e.il);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic m, input logic en_v, input logic u,
                     input logic l, input logic [7:0] lv, input bit big,
                     input logic [7:0] eq, input logic [3:0] eph, input logic ew,
                     input string nm);
    exp_t x;
    reset = r; mode = m; en = en_v; up = u; load = l; load_val8 = lv;
    @(posedge clk);
    x.big = big; x.q = eq; x.ph = eph; x.wr = ew; x.il = 1'b0; x.nm = nm;
    sb.push_back(x);
    #1;
  endtask

  initial begin
    // r  m  en up ld  lv     big q      ph  wr
    cyc(1, 0, 0, 1, 0, 8'h00, 0, 8'h0, 0, 0, "reset");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h4, 1, 0, "j_up1");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h6, 2, 0, "j_up2");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h7, 3, 0, "j_up3");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h3, 4, 0, "j_up4");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h1, 5, 0, "j_up5");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h0, 0, 1, "j_wrap");
    cyc(0, 0, 0, 1, 0, 8'h00, 0, 8'h0, 0, 0, "j_hold");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h4, 1, 0, "j_up_a");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h6, 2, 0, "j_up_b");
    cyc(0, 0, 1, 0, 0, 8'h00, 0, 8'h4, 1, 0, "j_down1");
    cyc(0, 0, 1, 0, 0, 8'h00, 0, 8'h0, 0, 1, "j_down_wrap");
    cyc(0, 0, 1, 1, 1, 8'h03, 0, 8'h3, 4, 0, "load_over_en");
    cyc(0, 1, 1, 1, 0, 8'h00, 0, 8'h4, 0, 0, "mode_to_ring");
    cyc(1, 1, 1, 0, 0, 8'h00, 0, 8'h4, 0, 0, "ring_reset");
    cyc(0, 1, 1, 0, 0, 8'h00, 0, 8'h1, 2, 0, "r_dn1");
    cyc(0, 1, 1, 0, 0, 8'h00, 0, 8'h2, 1, 0, "r_dn2");
    cyc(0, 1, 1, 0, 0, 8'h00, 0, 8'h4, 0, 1, "r_wrap1");
    cyc(0, 1, 1, 0, 0, 8'h00, 0, 8'h1, 2, 0, "r_dn4");
    cyc(0, 1, 1, 0, 0, 8'h00, 0, 8'h2, 1, 0, "r_dn5");
    cyc(0, 1, 1, 0, 0, 8'h00, 0, 8'h4, 0, 1, "r_wrap2");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h0, 0, 0, "mode_to_johnson");
`ifdef SHIFT_COUNTER_SELFCORRECT_EN
    cyc(0, 0, 0, 1, 1, 8'h05, 0, 8'h0, 0, 0, "load_illegal_fixed");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h4, 1, 0, "step_after_fix");
`else
    cyc(0, 0, 0, 1, 1, 8'h05, 0, 8'h5, 0, 0, "load_illegal_raw");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h2, 0, 0, "step_illegal_raw");
`endif
    cyc(1, 0, 0, 1, 0, 8'h00, 0, 8'h0, 0, 0, "reset2");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h4, 1, 0, "j2_up1");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h6, 2, 0, "j2_up2");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h7, 3, 0, "j2_up3");
    cyc(1, 0, 1, 1, 0, 8'h00, 0, 8'h0, 0, 0, "reset_mid_seq");
    cyc(0, 0, 1, 1, 0, 8'h00, 0, 8'h4, 1, 0, "after_reset_step");
    cyc(1, 1, 0, 1, 0, 8'h00, 1, 8'h80, 0, 0, "w8_reset");
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 1, 1, 1, 0, 8'h00, 1, 8'h80 >> (k % 8), 4'(k % 8), (k % 8) == 0, "w8_ring");
    end
    en = 1'b0;
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_counter.md
# shift_counter

Parametrised W-bit shift-register counter with run-time Johnson or ring mode, direction control, enable, parallel load, decoded phase index and wrap pulse. It generalises the team's fixed 3-bit Johnson counter for sequencers, multi-phase enables and glitch-free phase generation in downstream control logic. The block has a single clock domain and registered state, and decodes its outputs directly from state.

## Interface
- W, default 3: counter width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance one step this cycle.
- up  input  1  direction: 1 = up, 0 = down.
- mode  input  1  0 = Johnson (2W states), 1 = ring (W states).
- load  input  1  parallel load request.
- load_val  input  W  value written to q on load.
- q  output  W  counter state (registered).
- phase  output  $clog2(2W)  index of the current state in the sequence (combinational from q).
- wrap  output  1  one-cycle registered pulse on step into phase 0.
- illegal  output  1  q is not a legal pattern for the current mode (combinational).

## Operation
- Base state: Johnson = all zeros; ring = only q[W-1] set.
- Johnson step: up moves q to {~q[0], q[W-1:1]}; down moves q to {q[W-2:0], ~q[W-1]}.
- Ring step: up moves q to {q[0], q[W-1:1]}; down moves q to {q[W-2:0], q[W-1]}.
- Priority per clock edge:
  1. reset
  2. mode change
  3. load
  4. illegal-state correction
  5. en step
  6. hold
- Reset: q goes to the base state of the sampled mode, wrap goes to 0, and the registered mode copy is updated.
- Mode change: when mode differs from its registered copy, q is forced to the new mode's base state, en and load are ignored that cycle, and wrap stays 0.
- Load: q takes load_val and wrap stays 0. Checking depends on the macro (see Configuration).
- Johnson phase:
  - If q[W-1]=1 or q=0: phase = popcount(q).
  - Otherwise: phase = 2W − popcount(q).
- Ring phase: W−1−(index of the set bit).
- Illegal q: phase is 0.
- Legal Johnson pattern: a contiguous run of ones anchored at the MSB or at the LSB, including all zeros and all ones.
- Legal ring pattern: exactly one bit set.
- wrap = 1 in the cycle after an en step (either direction) whose next state is phase 0. Reset, load, mode change and correction never raise wrap.
- en=0 holds q, and wrap drops to 0.

## Timing
- State latency: q updates on the same clock edge that samples en, load or mode, and is visible in the following cycle.
- phase and illegal follow q combinationally: no extra latency, no registers.
- wrap has one cycle of latency relative to the step edge and lasts exactly one cycle per wrap.
- Continuous en in Johnson mode produces one wrap every 2W cycles. In ring mode the period is W cycles.
- Reset asserted mid-sequence overrides everything at the next edge. Reset is never asynchronous.
- load and en together: load wins and no step occurs that cycle.
- Reversing up mid-sequence takes effect at the next step with no dead cycle. Example (W=3, Johnson): phase 2 then down gives phase 1.

## Configuration
- Macro SHIFT_COUNTER_SELFCORRECT_EN.
- Defined:
  - An illegal load_val loads the base state instead.
  - Any cycle with illegal=1 and no reset, mode change or load forces q to the base state at the next edge, regardless of en.
  - illegal is driven from the legality decode.
- Undefined:
  - load_val loads unchecked.
  - Illegal patterns are stepped by the normal shift rules.
  - illegal is tied to 0. phase still decodes to 0 for illegal q.

## Structure
- Package shift_counter_pkg holds:
  - typedef enum logic {MODE_JOHNSON=1'b0, MODE_RING=1'b1} sc_mode_e;
  - the maximum-W constant;
  - a width-generic popcount function.
- Sub-module shift_counter_decode: purely combinational.
  - Inputs: q, mode.
  - Outputs: phase and legal.
  - Instantiated once. The verification model reuses it.
- The top holds q, the registered mode copy, wrap, next-state muxing and the correction logic.

## Test plan
All scenarios use W=3 unless stated otherwise.
- Reset then en=1, up=1, Johnson mode: q is 000, 100, 110, 111, 011, 001, 000. phase is 0..5 then 0. wrap pulses exactly once, in the cycle after the edge that returns q to 000.
- Ring mode, up=0, en=1 from reset: q is 100, 001, 010, 100. wrap pulses every 3 cycles.
- Johnson at q=110, set up=0 for two steps: q is 100, then 000, and wrap pulses.
- load=1, en=1, load_val=011: q=011, phase=4, no step, wrap=0. Then toggle mode to 1: q=100 next cycle, with the en step ignored.
- With SHIFT_COUNTER_SELFCORRECT_EN, Johnson load_val=101: q=000 and illegal stays 0. Without the macro: q=101, illegal=0, phase=0, and the next up step gives q=010.
- Reset asserted while en=1 at q=111: q=000 next cycle, wrap=0. W=8 ring mode: 8-cycle wrap period.
